// File: rtl/rs232_uart.sv
// rs232_uart: full-duplex 8N1 serial port with a fixed baud rate, bridging the
// UART pins to a byte-wide handshaked interface (ready/enable for transmit,
// one-cycle strobe for receive). Transmitter and receiver run independently.
`timescale 1ns/1ps
module rs232_uart #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_RXD,
    input  logic       UART_CTS,
    output logic       UART_RTS,
    output logic       UART_TXD,
    input  logic [7:0] TX,
    input  logic       en_TX,
    output logic       TX_ready,
    output logic [7:0] RX,
    output logic       hasRX
);
    localparam logic [31:0] CYCLES_PER_BIT = 32'(CLK_FREQ / BAUD_RATE);
    localparam logic [31:0] BIT_LAST       = CYCLES_PER_BIT - 32'd1;
    localparam logic [31:0] HALF_LAST      = (CYCLES_PER_BIT >> 1) - 32'd1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // Flow control is not used: always ready to receive, CTS is ignored.
    logic unused_cts;
    assign unused_cts = UART_CTS;
    assign UART_RTS   = 1'b0;

    tx_state_t   tx_state, tx_state_nxt;
    logic [31:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]  tx_idx, tx_idx_nxt;
    logic [7:0]  tx_shift, tx_shift_nxt;
    logic        txd_q, txd_nxt;

    rx_state_t   rx_state, rx_state_nxt;
    logic [31:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]  rx_idx, rx_idx_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic [7:0]  rx_byte, rx_byte_nxt;
    logic        has_rx, has_rx_nxt;
    logic        rxd_p0, rxd_p1;

    assign UART_TXD = txd_q;
    assign TX_ready = (tx_state == TX_IDLE);
    assign RX       = rx_byte;
    assign hasRX    = has_rx;

    // Transmitter registers: control is reset, the shift register only loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 32'd0;
            tx_idx   <= 3'd0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            txd_q    <= txd_nxt;
        end
        tx_shift <= tx_shift_nxt;
    end

    // Transmitter next state: each bit (start, data, stop) lasts CYCLES_PER_BIT clocks.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 32'd1;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        txd_nxt      = txd_q;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = 32'd0;
                txd_nxt    = 1'b1;
                if (en_TX) begin
                    tx_shift_nxt = TX;
                    tx_state_nxt = TX_START;
                    txd_nxt      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = 32'd0;
                    tx_idx_nxt   = 3'd0;
                    txd_nxt      = tx_shift[0];
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = 32'd0;
                    tx_shift_nxt = tx_shift >> 1;
                    if (tx_idx == 3'd7) begin
                        txd_nxt      = 1'b1;
                        tx_state_nxt = TX_STOP;
                    end else begin
                        txd_nxt    = tx_shift[1];
                        tx_idx_nxt = tx_idx + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = 32'd0;
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Receiver registers, including the two-flop synchroniser on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_p0   <= 1'b1;
            rxd_p1   <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 32'd0;
            rx_idx   <= 3'd0;
            rx_byte  <= 8'h00;
            has_rx   <= 1'b0;
        end else begin
            rxd_p0   <= UART_RXD;
            rxd_p1   <= rxd_p0;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_byte  <= rx_byte_nxt;
            has_rx   <= has_rx_nxt;
        end
        rx_shift <= rx_shift_nxt;
    end

    // Receiver next state: confirm start at half a bit, then sample mid-bit.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 32'd1;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_byte_nxt  = rx_byte;
        has_rx_nxt   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = 32'd0;
                if (!rxd_p1) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = 32'd0;
                    rx_idx_nxt   = 3'd0;
                    // A line already back high here was only a glitch.
                    rx_state_nxt = rxd_p1 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = 32'd0;
                    rx_shift_nxt = {rxd_p1, rx_shift[7:1]};
                    if (rx_idx == 3'd7) rx_state_nxt = RX_STOP;
                    else                rx_idx_nxt   = rx_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = 32'd0;
                    if (rxd_p1) begin
                        rx_byte_nxt  = rx_shift;
                        has_rx_nxt   = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        // Framing error: drop the byte, re-arm once the line idles.
                        rx_state_nxt = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_nxt = 32'd0;
                if (rxd_p1) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rs232_uart.sv
// Directed bench for rs232_uart, run with a short bit time (400 clocks/bit).
`timescale 1ns/1ps
module tb_rs232_uart;
    localparam int CPB = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       UART_RXD;
    logic       UART_CTS;
    logic       UART_RTS;
    logic       UART_TXD;
    logic [7:0] TX;
    logic       en_TX;
    logic       TX_ready;
    logic [7:0] RX;
    logic       hasRX;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rx_pulses    = 0;
    int rx_pulse_cyc = 0;
    int rx_fall_cyc  = 0;
    logic [7:0] rx_last = 8'h00;

    rs232_uart #(.CLK_FREQ(4_000_000), .BAUD_RATE(10_000)) dut (
        .clk(clk), .rst(rst), .UART_RXD(UART_RXD), .UART_CTS(UART_CTS),
        .UART_RTS(UART_RTS), .UART_TXD(UART_TXD), .TX(TX), .en_TX(en_TX),
        .TX_ready(TX_ready), .RX(RX), .hasRX(hasRX)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Record every cycle in which the receive strobe is high.
    always @(negedge clk) begin
        if (hasRX === 1'b1) begin
            rx_pulses    = rx_pulses + 1;
            rx_last      = RX;
            rx_pulse_cyc = cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic drive_rx_frame(input logic [7:0] data, input logic stop_bit);
        @(negedge clk);
        UART_RXD    = 1'b0;
        rx_fall_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = data[i];
            repeat (CPB) @(negedge clk);
        end
        UART_RXD = stop_bit;
        repeat (CPB) @(negedge clk);
        UART_RXD = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; UART_CTS = 1'bx; UART_RXD = 1'b1; en_TX = 1'b0; TX = 8'h00;
        @(posedge clk); #1;
        checks++; if (TX_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready: got %b expected 1", TX_ready); end
        checks++; if (UART_TXD !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", UART_TXD); end
        checks++; if (hasRX !== 1'b0) begin failures++; $display("FAIL reset_hasrx: got %b expected 0", hasRX); end
        checks++; if (RX !== 8'h00) begin failures++; $display("FAIL reset_rx: got %h expected 00", RX); end
        checks++; if (UART_RTS !== 1'b0) begin failures++; $display("FAIL reset_rts: got %b expected 0", UART_RTS); end
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_receive();
        int lat;
        rx_pulses = 0;
        drive_rx_frame(8'h05, 1'b1);
        repeat (5) @(negedge clk);
        lat = rx_pulse_cyc - rx_fall_cyc;
        checks++; if (rx_pulses !== 1) begin failures++; $display("FAIL rx05_pulses: got %0d expected 1", rx_pulses); end
        checks++; if (rx_last !== 8'h05) begin failures++; $display("FAIL rx05_value: got %h expected 05", rx_last); end
        checks++; if (RX !== 8'h05) begin failures++; $display("FAIL rx05_hold: got %h expected 05", RX); end
        checks++; if (lat < 3800 || lat > 3806) begin failures++; $display("FAIL rx05_latency: got %0d expected 3800..3806", lat); end
    endtask

    task automatic test_transmit(input logic [7:0] data, input logic [9:0] exp_frame, input string tag);
        int bad;
        @(negedge clk); TX = data; en_TX = 1'b1;
        @(posedge clk); #1;
        checks++; if (TX_ready !== 1'b0) begin failures++; $display("FAIL %s_ready_drop: got %b expected 0", tag, TX_ready); end
        checks++; if (UART_TXD !== 1'b0) begin failures++; $display("FAIL %s_start_edge: got %b expected 0", tag, UART_TXD); end
        repeat (CPB/2) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (CPB) @(posedge clk);
            #1;
            checks++; if (UART_TXD !== exp_frame[k]) begin failures++; $display("FAIL %s_bit%0d: got %b expected %b", tag, k, UART_TXD, exp_frame[k]); end
            if (k == 1) begin en_TX = 1'b0; TX = 8'hFF; end
        end
        repeat (CPB/2 - 1) @(posedge clk); #1;
        checks++; if (TX_ready !== 1'b0) begin failures++; $display("FAIL %s_ready_last_busy: got %b expected 0", tag, TX_ready); end
        @(posedge clk); #1;
        checks++; if (TX_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_return: got %b expected 1", tag, TX_ready); end
        bad = 0;
        repeat (2*CPB) begin
            @(posedge clk); #1;
            if (UART_TXD !== 1'b1 || TX_ready !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL %s_no_second_frame: got %0d busy cycles expected 0", tag, bad); end
    endtask

    task automatic test_simultaneous();
        rx_pulses = 0;
        fork
            test_transmit(8'hCA, 10'b1110010100, "sim_txCA");
            drive_rx_frame(8'h05, 1'b1);
        join
        checks++; if (rx_pulses !== 1) begin failures++; $display("FAIL sim_rx_pulses: got %0d expected 1", rx_pulses); end
        checks++; if (rx_last !== 8'h05) begin failures++; $display("FAIL sim_rx_value: got %h expected 05", rx_last); end
    endtask

    task automatic test_framing();
        rx_pulses = 0;
        drive_rx_frame(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (rx_pulses !== 0) begin failures++; $display("FAIL frm_err_pulses: got %0d expected 0", rx_pulses); end
        checks++; if (RX !== 8'h05) begin failures++; $display("FAIL frm_err_rx_kept: got %h expected 05", RX); end
        drive_rx_frame(8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (rx_pulses !== 1) begin failures++; $display("FAIL frm_next_pulses: got %0d expected 1", rx_pulses); end
        checks++; if (RX !== 8'h3C) begin failures++; $display("FAIL frm_next_value: got %h expected 3c", RX); end
    endtask

    task automatic test_glitch();
        rx_pulses = 0;
        @(negedge clk); UART_RXD = 1'b0;
        repeat (100) @(negedge clk);
        UART_RXD = 1'b1;
        repeat (11*CPB) @(negedge clk);
        checks++; if (rx_pulses !== 0) begin failures++; $display("FAIL glitch_pulses: got %0d expected 0", rx_pulses); end
        checks++; if (RX !== 8'h3C) begin failures++; $display("FAIL glitch_rx_kept: got %h expected 3c", RX); end
        drive_rx_frame(8'h81, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if (rx_pulses !== 1 || rx_last !== 8'h81) begin failures++; $display("FAIL glitch_rearm: got %0d pulses value %h expected 1 pulse value 81", rx_pulses, rx_last); end
    endtask

    task automatic test_tx_reset();
        int bad;
        @(negedge clk); TX = 8'hCA; en_TX = 1'b1;
        @(posedge clk);
        @(negedge clk); en_TX = 1'b0;
        repeat (CPB + CPB/2 - 1) @(posedge clk); #1;
        checks++; if (UART_TXD !== 1'b0 || TX_ready !== 1'b0) begin failures++; $display("FAIL abort_mid_frame: got txd %b ready %b expected 0 0", UART_TXD, TX_ready); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (UART_TXD !== 1'b1) begin failures++; $display("FAIL abort_txd: got %b expected 1", UART_TXD); end
        checks++; if (TX_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", TX_ready); end
        checks++; if (RX !== 8'h00) begin failures++; $display("FAIL abort_rx_cleared: got %h expected 00", RX); end
        @(negedge clk); rst = 1'b0;
        bad = 0;
        repeat (CPB) begin
            @(negedge clk);
            if (UART_TXD !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL abort_stays_idle: got %0d low cycles expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_receive();
        test_transmit(8'hCA, 10'b1110010100, "txCA");
        test_simultaneous();
        test_framing();
        test_glitch();
        test_tx_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs232_uart.md
# rs232_uart

Full-duplex 8N1 UART (RS-232 serial port) with a fixed, parameterised baud rate. It bridges the board's UART pins to a byte-wide, handshaked parallel interface used by the rest of the computer. A transmit byte is accepted through a ready/enable handshake, and each received byte is reported with a one-cycle strobe.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- Derived constant `CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE`, integer-truncated; 5208 at the defaults.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `UART_RXD`  in  1  serial receive line; idles high.
- `UART_CTS`  in  1  clear-to-send; ignored, may be X or undriven.
- `UART_RTS`  out  1  request-to-send; constant 0 (always ready).
- `UART_TXD`  out  1  serial transmit line; idles high.
- `TX`  in  8  byte to transmit.
- `en_TX`  in  1  transmit request.
- `TX_ready`  out  1  high when the transmitter is idle and can accept a byte.
- `RX`  out  8  last correctly received byte.
- `hasRX`  out  1  one-cycle strobe: `RX` has just been updated.

## Operation
- Frame format: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1). No parity. Every bit lasts exactly `CYCLES_PER_BIT` clocks.
- Reset values: `UART_TXD`=1, `TX_ready`=1, `RX`=8'h00, `hasRX`=0, `UART_RTS`=0. Both state machines go to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame immediately. `UART_TXD` returns to 1 on the next edge.
- Transmitter states: IDLE → START → DATA(0..7) → STOP → IDLE.
  - In IDLE, `en_TX`=1 at an edge captures `TX` into a shift register, drops `TX_ready`, and enters START.
  - `TX` and `en_TX` are ignored while busy.
  - `en_TX` is level-sensitive. If it is still high when the machine returns to IDLE, a new frame starts with the current `TX`.
- Receiver:
  - `UART_RXD` passes through a 2-flop synchroniser before any use.
  - States: IDLE → START → DATA(0..7) → STOP → IDLE.
  - In IDLE, a synchronised low level starts the START state with a counter.
  - At `CYCLES_PER_BIT/2` the line is rechecked. If it is high, the event is a glitch and the receiver returns to IDLE.
  - Each data bit is sampled `CYCLES_PER_BIT` after the previous sample point (mid-bit) and shifted in LSB first.
  - At the stop-bit sample point, a line of 1 loads `RX` with the shifted byte and pulses `hasRX` for one clock.
  - A stop bit of 0 is a framing error: the byte is discarded, `hasRX` stays low, and `RX` is unchanged. The receiver then waits for the line to return high before re-arming.
  - After a good stop sample the receiver returns to IDLE at once, so back-to-back frames are accepted.
- `RX` holds its value between frames.
- TX and RX are fully independent and may run simultaneously.
- Bit counter is 32 bits wide; division rounding error is tolerated.

## Timing
- Transmit latency:
  - `en_TX` sampled high at edge N (idle) gives `TX_ready`=0 and `UART_TXD`=0 after edge N.
  - Each bit, including the stop bit, holds for `CYCLES_PER_BIT` clocks.
  - `TX_ready` returns to 1 exactly `10*CYCLES_PER_BIT` clocks after edge N. The earliest next frame start is at that edge.
- Receive latency:
  - `hasRX` rises about 2–3 clocks (synchroniser delay) after the middle of the stop bit.
  - That is roughly `9.5*CYCLES_PER_BIT + 3` clocks after the start-bit falling edge.
  - `hasRX` is high for exactly 1 clock, and `RX` is valid in that same cycle.
- A start edge arriving during a stop-bit wait is not missed; the receiver accepts the next frame immediately after the stop sample.

## Test plan
- Reset: hold `rst`=1 for 1 edge → `TX_ready`=1, `UART_TXD`=1, `hasRX`=0, `RX`=0, `UART_RTS`=0, with `UART_CTS` left X.
- Receive 0x05: drive line bits 0,1,0,1,0,0,0,0,0,1, each `CYCLES_PER_BIT` clocks (5208) → exactly one `hasRX` pulse with `RX`=8'b00000101; `hasRX` is never high with any other value.
- Transmit 0xCA:
  - Stimulus: `en_TX`=1 for one bit time while idle.
  - Required: `UART_TXD` = 0,0,1,0,1,0,0,1,1,1, each 5208 clocks; `TX_ready` low for 52080 clocks, then high; no second frame.
- Simultaneous traffic: transmit 0xCA while receiving 0x05 → both frames complete correctly and unchanged.
- Framing error: send a frame for 0xA5 with the stop bit forced to 0 → no `hasRX` pulse and `RX` unchanged. A following valid 0x3C frame is received correctly.
- Glitch rejection and abort:
  - A low pulse of 100 clocks on `UART_RXD` → no reception.
  - `rst` asserted mid-transmit → `UART_TXD`=1 and `TX_ready`=1 on the next edge.
